// File: rtl/mips_pkg.sv
// Shared ISA encodings, FSM state and ALU operation types for the multi-cycle core.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} fsm_state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;

    // True when opcode (and funct for R-type) is part of the supported subset.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operation for an instruction; branches compare by subtraction.
    function automatic alu_op_t alu_decode(input logic [5:0] op, input logic [5:0] fn);
        alu_op_t res;
        res = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_SUB:  res = ALU_SUB;
                FN_AND:  res = ALU_AND;
                FN_OR:   res = ALU_OR;
                FN_SLT:  res = ALU_SLT;
                FN_SLL:  res = ALU_SLL;
                FN_SRL:  res = ALU_SRL;
                default: res = ALU_ADD;
            endcase
        end else if (op == OP_BEQ || op == OP_BNE) begin
            res = ALU_SUB;
        end
        return res;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU.
// Ports: op (operation), a/b (operands), shamt (shift amount applied to b),
//        result (wrap-around result), zero (result == 0).
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [4:0]       shamt,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    logic lt;

    assign lt = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS-subset core with req/ack instruction and data memory ports.
// Ports: clk, rst (sync active-high); imem_req/imem_addr/imem_ack/imem_rdata fetch port;
//        dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata data port;
//        halted (sticky fault flag, cleared only by rst).
module multi_cycle_mips
    import mips_pkg::*;
#(
    parameter int unsigned DADDR_W  = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic               halted
);

    fsm_state_t state, state_next;
    logic [XLEN-1:0] pc, ir, a, b, alu_out, mdr;
    logic [XLEN-1:0] rf [32];

    logic [5:0]        opcode, funct;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   sext_imm, pc4, br_target, jmp_target, alu_b, alu_res;
    logic              alu_zero;
    alu_op_t           alu_op;

    logic              pc_we, ir_we, ab_we, alu_we, mdr_we, mem_setup, rf_we;
    logic [XLEN-1:0]   pc_d, rf_wdata;
    logic [REG_AW-1:0] rf_waddr;

    assign opcode     = ir[31:26];
    assign rs         = ir[25:21];
    assign rt         = ir[20:16];
    assign rd         = ir[15:11];
    assign shamt      = ir[10:6];
    assign funct      = ir[5:0];
    assign sext_imm   = {{16{ir[15]}}, ir[15:0]};
    assign pc4        = pc + 32'd4;
    assign br_target  = pc4 + {sext_imm[29:0], 2'b00};
    assign jmp_target = {pc4[31:28], ir[25:0], 2'b00};
    assign alu_op     = alu_decode(opcode, funct);
    // Register operand for R-type and branch compares, immediate otherwise.
    assign alu_b      = (opcode == OP_RTYPE || opcode == OP_BEQ || opcode == OP_BNE) ? b : sext_imm;
    assign imem_addr  = pc;

    mips_alu u_alu (
        .op     (alu_op),
        .a      (a),
        .b      (alu_b),
        .shamt  (shamt),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        pc_d       = pc4;
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        alu_we     = 1'b0;
        mdr_we     = 1'b0;
        mem_setup  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rd;
        rf_wdata   = alu_out;
        unique case (state)
            FETCH: begin
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!is_legal(opcode, funct)) begin
                    state_next = HALT;
                end else begin
                    ab_we      = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = FETCH;
                case (opcode)
                    OP_BEQ, OP_BNE: begin
                        pc_we = 1'b1;
                        // bne inverts the equality outcome
                        pc_d  = (alu_zero ^ (opcode == OP_BNE)) ? br_target : pc4;
                    end
                    OP_J: begin
                        pc_we = 1'b1;
                        pc_d  = jmp_target;
                    end
                    OP_JAL: begin
                        pc_we    = 1'b1;
                        pc_d     = jmp_target;
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc4;
                    end
                    OP_LW, OP_SW: begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_next = HALT;
                        end else begin
                            mem_setup  = 1'b1;
                            state_next = MEM;
                        end
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_we = 1'b1;
                            pc_d  = a;
                        end else begin
                            alu_we     = 1'b1;
                            state_next = WB;
                        end
                    end
                    default: begin
                        alu_we     = 1'b1;
                        state_next = WB;
                    end
                endcase
            end
            MEM: begin
                if (dmem_ack) begin
                    if (opcode == OP_LW) begin
                        mdr_we     = 1'b1;
                        state_next = WB;
                    end else begin
                        pc_we      = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            WB: begin
                rf_we      = 1'b1;
                rf_waddr   = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata   = (opcode == OP_LW) ? mdr : alu_out;
                pc_we      = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // State, datapath registers and registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            // Reset lands in FETCH, so the fetch request is live on the first cycle.
            imem_req   <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == FETCH);
            dmem_req <= (state_next == MEM);
            halted   <= (state_next == HALT);
            if (pc_we)  pc      <= pc_d;
            if (ir_we)  ir      <= imem_rdata;
            if (ab_we) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (alu_we) alu_out <= alu_res;
            if (mdr_we) mdr     <= dmem_rdata;
            if (mem_setup) begin
                alu_out    <= alu_res;
                dmem_we    <= (opcode == OP_SW);
                dmem_addr  <= alu_res[DADDR_W+1:2];
                dmem_wdata <= b;
            end
        end
    end

    // Register file; $0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

endmodule
